uba_xfer_monitor: RTL and testbench

Transaction watchdog for the Unibus Adapter. Watches KS10-initiated IO cycles to Unibus devices and device-initiated DMA cycles to KS10 memory. If the responder does not acknowledge in time, it terminates the stalled cycle and pulses the `setNXD` / `setTMO` inputs of the UBA status register. It sits between the UBA bus-interface logic and the status register, one instance per UBA.

---
 rtl/uba_xfer_pkg.sv | 15 +
 rtl/uba_xfer_monitor_if.sv | 28 ++
 rtl/uba_xfer_timer.sv | 90 +++++++++
 rtl/uba_xfer_monitor.sv | 50 +++++
 tb/tb_uba_xfer_monitor.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uba_xfer_pkg.sv
// Shared definitions for the UBA transfer watchdog.
//   xfer_state_e   : per-side state encoding (IDLE / WAIT / ABORT)
//   *_CYCLES_DEF   : default acknowledge limits for the IO and DMA sides
package uba_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } xfer_state_e;

  localparam int NXD_CYCLES_DEF = 64;
  localparam int TMO_CYCLES_DEF = 256;

endpackage

// File: rtl/uba_xfer_monitor_if.sv
// Handshake bundle between the UBA bus-interface logic, the watchdog and the
// UBA status register.
//   master : bus-interface side. It drives the requests, acks and init, and it
//            observes busy, abort and set pulses.
//   slave  : watchdog side (uba_xfer_monitor).
interface uba_xfer_monitor_if;
  logic ioREQ;
  logic devACK;
  logic dmaREQ;
  logic memACK;
  logic statINI;
  logic ioBUSY;
  logic ioABORT;
  logic dmaBUSY;
  logic dmaABORT;
  logic setNXD;
  logic setTMO;

  modport master (
    output ioREQ, devACK, dmaREQ, memACK, statINI,
    input  ioBUSY, ioABORT, dmaBUSY, dmaABORT, setNXD, setTMO
  );

  modport slave (
    input  ioREQ, devACK, dmaREQ, memACK, statINI,
    output ioBUSY, ioABORT, dmaBUSY, dmaABORT, setNXD, setTMO
  );
endinterface

// File: rtl/uba_xfer_timer.sv
// Acknowledge watchdog for one bus side.
//   clk, rst : clock and synchronous active-high reset
//   clr      : silent abort to IDLE. It overrides req and does not pulse.
//   req      : one-clock pulse that starts a cycle. It is ignored unless the side is IDLE.
//   ack      : responder acknowledge. It is only looked at in WAIT.
//   busy     : registered. It is high while the side is in WAIT.
//   abort    : registered. It is a one-clock pulse when the cycle timed out.
// With req at edge 0 and no ack, the side spends exactly LIMIT clocks in WAIT.
// The counter loads LIMIT-1 and reaches 0 after edge LIMIT-1. The expiry is
// taken at edge LIMIT.
module uba_xfer_timer
  import uba_xfer_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic busy,
  output logic abort
);

  localparam int            CW   = $clog2(LIMIT);
  localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

  xfer_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // An ack in the same clock as req is not seen until WAIT.
        if (req) begin
          state_d = ST_WAIT;
          cnt_d   = LOAD;
        end
      end
      ST_WAIT: begin
        // If ack and expiry happen together, ack wins.
        if (ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    // The outputs are decoded from the next state, so they stay registered.
    busy_d  = (state_d == ST_WAIT);
    abort_d = (state_d == ST_ABORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign busy  = busy_q;
  assign abort = abort_q;

endmodule

// File: rtl/uba_xfer_monitor.sv
// UBA transaction watchdog. There is one instance per UBA.
//   clk, rst : clock and synchronous active-high reset
//   bus      : uba_xfer_monitor_if.slave
//              ioREQ/devACK  : KS10 to Unibus IO cycle. It times out to setNXD.
//              dmaREQ/memACK : Unibus to KS10 DMA cycle. It times out to setTMO.
//              statINI       : UBA init. It silently aborts both sides.
//              *BUSY / *ABORT / setNXD / setTMO : registered status outputs
// The two sides are independent. They may abort in the same clock, and the
// status register merges the simultaneous set pulses.
module uba_xfer_monitor
  import uba_xfer_pkg::*;
#(
  parameter int NXD_CYCLES = NXD_CYCLES_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst,
  uba_xfer_monitor_if.slave bus
);

  logic io_busy, io_abort, dma_busy, dma_abort;

  uba_xfer_timer #(.LIMIT(NXD_CYCLES)) u_io (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.statINI),
    .req   (bus.ioREQ),
    .ack   (bus.devACK),
    .busy  (io_busy),
    .abort (io_abort)
  );

  uba_xfer_timer #(.LIMIT(TMO_CYCLES)) u_dma (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.statINI),
    .req   (bus.dmaREQ),
    .ack   (bus.memACK),
    .busy  (dma_busy),
    .abort (dma_abort)
  );

  assign bus.ioBUSY   = io_busy;
  assign bus.ioABORT  = io_abort;
  assign bus.dmaBUSY  = dma_busy;
  assign bus.dmaABORT = dma_abort;
  assign bus.setNXD   = io_abort;
  assign bus.setTMO   = dma_abort;

endmodule

// File: tb/tb_uba_xfer_monitor.sv
// Directed bench. dut_a uses the default limits (64/256). dut_b uses 16/16.
// The inputs change 1 time unit after a rising edge. The outputs are checked at
// the same point, so each check reflects the edge just taken.
module tb_uba_xfer_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uba_xfer_monitor_if ifa ();
  uba_xfer_monitor_if ifb ();

  uba_xfer_monitor dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  uba_xfer_monitor #(.NXD_CYCLES(16), .TMO_CYCLES(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a_all0(input string tag);
    chk({tag, ".a.ioBUSY"},   ifa.ioBUSY,   1'b0);
    chk({tag, ".a.ioABORT"},  ifa.ioABORT,  1'b0);
    chk({tag, ".a.dmaBUSY"},  ifa.dmaBUSY,  1'b0);
    chk({tag, ".a.dmaABORT"}, ifa.dmaABORT, 1'b0);
    chk({tag, ".a.setNXD"},   ifa.setNXD,   1'b0);
    chk({tag, ".a.setTMO"},   ifa.setTMO,   1'b0);
  endtask

  task automatic chk_b_all0(input string tag);
    chk({tag, ".b.ioBUSY"},   ifb.ioBUSY,   1'b0);
    chk({tag, ".b.ioABORT"},  ifb.ioABORT,  1'b0);
    chk({tag, ".b.dmaBUSY"},  ifb.dmaBUSY,  1'b0);
    chk({tag, ".b.dmaABORT"}, ifb.dmaABORT, 1'b0);
    chk({tag, ".b.setNXD"},   ifb.setNXD,   1'b0);
    chk({tag, ".b.setTMO"},   ifb.setTMO,   1'b0);
  endtask

  initial begin
    {ifa.ioREQ, ifa.devACK, ifa.dmaREQ, ifa.memACK, ifa.statINI} = '0;
    {ifb.ioREQ, ifb.devACK, ifb.dmaREQ, ifb.memACK, ifb.statINI} = '0;

    // Reset state
    rst = 1'b1;
    steps(2);
    chk_a_all0("reset");
    chk_b_all0("reset");
    rst = 1'b0;
    step();

    // IO req, then devACK at edge 5: busy for 5 clocks and no NXD
    ifa.ioREQ = 1'b1; step(); ifa.ioREQ = 1'b0;           // edge 0
    chk("ack5.busy_e0", ifa.ioBUSY, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("ack5.busy", ifa.ioBUSY, 1'b1);
    end
    ifa.devACK = 1'b1; step(); ifa.devACK = 1'b0;         // edge 5
    chk("ack5.busy_drop", ifa.ioBUSY, 1'b0);
    chk("ack5.nxd", ifa.setNXD, 1'b0);
    for (int k = 0; k < 70; k++) begin
      step();
      chk("ack5.no_nxd_later", ifa.setNXD, 1'b0);
    end

    // IO req, no ack: a 1-clock NXD pulse after edge 64
    ifa.ioREQ = 1'b1; step(); ifa.ioREQ = 1'b0;           // edge 0
    for (int k = 1; k <= 63; k++) begin
      step();
      chk("nxd.busy_wait", ifa.ioBUSY, 1'b1);
      chk("nxd.no_early_abort", ifa.ioABORT, 1'b0);
    end
    step();                                                // edge 64
    chk("nxd.busy_fall", ifa.ioBUSY, 1'b0);
    chk("nxd.ioABORT", ifa.ioABORT, 1'b1);
    chk("nxd.setNXD", ifa.setNXD, 1'b1);
    chk("nxd.setTMO_quiet", ifa.setTMO, 1'b0);
    step();
    chk("nxd.ioABORT_end", ifa.ioABORT, 1'b0);
    chk("nxd.setNXD_end", ifa.setNXD, 1'b0);
    chk("nxd.busy_idle", ifa.ioBUSY, 1'b0);

    // devACK on the expiry edge 64: ack wins
    step();
    ifa.ioREQ = 1'b1; step(); ifa.ioREQ = 1'b0;           // edge 0
    steps(63);
    chk("race.busy_e63", ifa.ioBUSY, 1'b1);
    ifa.devACK = 1'b1; step(); ifa.devACK = 1'b0;         // edge 64
    chk("race.busy_drop", ifa.ioBUSY, 1'b0);
    chk("race.no_nxd", ifa.setNXD, 1'b0);
    chk("race.no_abort", ifa.ioABORT, 1'b0);
    step();
    chk("race.no_nxd_next", ifa.setNXD, 1'b0);

    // dut_b: both sides expire together. The IO re-req at clock 8 is ignored.
    ifb.ioREQ = 1'b1; ifb.dmaREQ = 1'b1; step();          // edge 0
    ifb.ioREQ = 1'b0; ifb.dmaREQ = 1'b0;
    steps(7);                                              // edges 1..7
    ifb.ioREQ = 1'b1; step(); ifb.ioREQ = 1'b0;           // edge 8
    steps(7);                                              // edges 9..15
    chk("both.io_busy_e15", ifb.ioBUSY, 1'b1);
    chk("both.no_early_nxd", ifb.setNXD, 1'b0);
    step();                                                // edge 16
    chk("both.setNXD", ifb.setNXD, 1'b1);
    chk("both.setTMO", ifb.setTMO, 1'b1);
    chk("both.ioBUSY_fall", ifb.ioBUSY, 1'b0);
    chk("both.dmaBUSY_fall", ifb.dmaBUSY, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("both.single_nxd", ifb.setNXD, 1'b0);
      chk("both.io_idle", ifb.ioBUSY, 1'b0);
    end

    // dut_b: req and ack in the same IDLE clock enter WAIT. The ack is seen next edge.
    ifb.ioREQ = 1'b1; ifb.devACK = 1'b1; step(); ifb.ioREQ = 1'b0;
    chk("reqack.busy", ifb.ioBUSY, 1'b1);
    step(); ifb.devACK = 1'b0;
    chk("reqack.busy_drop", ifb.ioBUSY, 1'b0);
    chk("reqack.no_nxd", ifb.setNXD, 1'b0);

    // statINI at clock 10 of a DMA wait (256)
    ifa.dmaREQ = 1'b1; step(); ifa.dmaREQ = 1'b0;         // edge 0
    steps(9);
    chk("ini.busy_before", ifa.dmaBUSY, 1'b1);
    ifa.statINI = 1'b1; ifa.dmaREQ = 1'b1; step();        // edge 10. The req must be ignored.
    ifa.dmaREQ = 1'b0;
    chk("ini.busy_drop", ifa.dmaBUSY, 1'b0);
    chk("ini.no_abort", ifa.dmaABORT, 1'b0);
    step();                                                // req while INI is high
    ifa.statINI = 1'b0;
    chk("ini.req_ignored", ifa.dmaBUSY, 1'b0);
    for (int k = 0; k < 300; k++) begin
      step();
      chk("ini.never_tmo", ifa.setTMO, 1'b0);
    end
    ifa.dmaREQ = 1'b1; step(); ifa.dmaREQ = 1'b0;         // edge 0
    chk("tmo.busy", ifa.dmaBUSY, 1'b1);
    steps(254);                                            // edges 1..254
    step();                                                // edge 255
    chk("tmo.no_early", ifa.setTMO, 1'b0);
    chk("tmo.busy_e255", ifa.dmaBUSY, 1'b1);
    step();                                                // edge 256
    chk("tmo.setTMO", ifa.setTMO, 1'b1);
    chk("tmo.dmaABORT", ifa.dmaABORT, 1'b1);
    chk("tmo.busy_fall", ifa.dmaBUSY, 1'b0);
    chk("tmo.nxd_quiet", ifa.setNXD, 1'b0);
    step();
    chk("tmo.pulse_end", ifa.setTMO, 1'b0);

    // rst during the ABORT clock clears everything
    ifb.ioREQ = 1'b1; step(); ifb.ioREQ = 1'b0;           // edge 0
    steps(16);                                             // edge 16: now in ABORT
    chk("rstab.abort_seen", ifb.ioABORT, 1'b1);
    rst = 1'b1; step();
    chk_b_all0("rstab");
    chk_a_all0("rstab");
    rst = 1'b0;

    // rst in mid-WAIT drops busy and no pulse follows
    ifb.dmaREQ = 1'b1; step(); ifb.dmaREQ = 1'b0;
    steps(5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstwait.busy", ifb.dmaBUSY, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("rstwait.no_tmo", ifb.setTMO, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
